// File: rtl/antares_clz_unit_if.sv
// Request/response bundle between the ALU control and antares_clz_unit.
// The ALU control (master) drives the operand and handshake requests.
// The counter (slave) returns busy/ready status plus the count and the normalized operand.
interface antares_clz_unit_if;
    logic [31:0] clz_operand;
    logic        clz_op;
    logic        clz_start;
    logic        clz_abort;
    logic        clz_busy;
    logic        clz_ready;
    logic [31:0] clz_result;
    logic [31:0] clz_normalized;

    modport master (
        output clz_operand, clz_op, clz_start, clz_abort,
        input  clz_busy, clz_ready, clz_result, clz_normalized
    );

    modport slave (
        input  clz_operand, clz_op, clz_start, clz_abort,
        output clz_busy, clz_ready, clz_result, clz_normalized
    );
endinterface

// File: rtl/antares_clz_unit.sv
// antares_clz_unit: iterative CLZ/CLO for MIPS32.
//
// CLO is folded into CLZ by inverting the operand on entry. The leading-zero
// count is then found by a 5-step binary search (16/8/4/2/1 bits, one step per
// cycle). An all-zero work word skips the search and completes in one cycle.
//
// Optional feature, macro ANTARES_CLZ_NORMALIZE_EN:
//   defined   - clz_normalized = original operand << count (0 when count = 32)
//   undefined - clz_normalized tied to 32'h0, and the operand copy is not built
module antares_clz_unit (
    input  logic                clk,
    input  logic                rst,
    antares_clz_unit_if.slave   clz_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } clz_state_t;

    clz_state_t  state_r;
    clz_state_t  state_s;

    logic [2:0]  step_r;
    logic [31:0] work_r;
    logic [5:0]  count_r;
    logic [5:0]  result_r;
    logic        busy_r;
    logic        ready_r;

    logic [31:0] start_work_s;
    logic [5:0]  width_s;
    logic        field_zero_s;
    logic [31:0] step_work_s;
    logic [5:0]  step_count_s;
    logic        accept_s;
    logic        load_result_s;
    logic [5:0]  done_count_s;

    // Inverting for CLO lets the search below always look for leading zeros.
    assign start_work_s = clz_if.clz_operand ^ {32{clz_if.clz_op}};

    // Current search window width and whether the top of work is all zeros in it.
    always_comb begin
        width_s      = 6'd0;
        field_zero_s = 1'b0;
        case (step_r)
            3'd0: begin width_s = 6'd16; field_zero_s = (work_r[31:16] == 16'h0000); end
            3'd1: begin width_s = 6'd8;  field_zero_s = (work_r[31:24] == 8'h00);    end
            3'd2: begin width_s = 6'd4;  field_zero_s = (work_r[31:28] == 4'h0);     end
            3'd3: begin width_s = 6'd2;  field_zero_s = (work_r[31:30] == 2'b00);    end
            3'd4: begin width_s = 6'd1;  field_zero_s = (work_r[31] == 1'b0);        end
            default: begin width_s = 6'd0; field_zero_s = 1'b0; end
        endcase
    end

    // One binary-search step: consume the window when it holds only zeros.
    always_comb begin
        step_work_s  = work_r;
        step_count_s = count_r;
        if (field_zero_s) begin
            step_work_s  = work_r << width_s;
            step_count_s = count_r + width_s;
        end else begin
            step_work_s  = work_r;
            step_count_s = count_r;
        end
    end

    // Next-state logic plus the accept / result-load strobes.
    always_comb begin
        state_s       = state_r;
        accept_s      = 1'b0;
        load_result_s = 1'b0;
        done_count_s  = step_count_s;
        case (state_r)
            ST_IDLE: begin
                if (clz_if.clz_start && !clz_if.clz_abort) begin
                    accept_s = 1'b1;
                    if (start_work_s == 32'h0000_0000) begin
                        state_s       = ST_DONE;
                        load_result_s = 1'b1;
                        done_count_s  = 6'd32;
                    end else begin
                        state_s = ST_SCAN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (clz_if.clz_abort) begin
                    state_s = ST_IDLE;
                end else if (step_r == 3'd4) begin
                    state_s       = ST_DONE;
                    load_result_s = 1'b1;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered handshake outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            busy_r  <= (state_s != ST_IDLE);
            ready_r <= (state_s == ST_DONE);
        end
    end

    // Search datapath: work word, running count, step index and held result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            work_r   <= 32'h0000_0000;
            count_r  <= 6'd0;
            step_r   <= 3'd0;
            result_r <= 6'd0;
        end else begin
            if (accept_s) begin
                work_r  <= start_work_s;
                count_r <= (start_work_s == 32'h0000_0000) ? 6'd32 : 6'd0;
                step_r  <= 3'd0;
            end else if ((state_r == ST_SCAN) && !clz_if.clz_abort) begin
                work_r  <= step_work_s;
                count_r <= step_count_s;
                step_r  <= step_r + 3'd1;
            end else begin
                work_r  <= work_r;
                count_r <= count_r;
                step_r  <= step_r;
            end
            if (load_result_s) begin
                result_r <= done_count_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

`ifdef ANTARES_CLZ_NORMALIZE_EN
    logic [31:0] operand_r;
    logic [31:0] norm_r;

    // Keep the untouched operand and produce its normalized form on completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            operand_r <= 32'h0000_0000;
            norm_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                operand_r <= clz_if.clz_operand;
            end else begin
                operand_r <= operand_r;
            end
            if (load_result_s) begin
                norm_r <= (done_count_s == 6'd32) ? 32'h0000_0000 : (operand_r << done_count_s);
            end else begin
                norm_r <= norm_r;
            end
        end
    end

    assign clz_if.clz_normalized = norm_r;
`else
    assign clz_if.clz_normalized = 32'h0000_0000;
`endif

    assign clz_if.clz_busy   = busy_r;
    assign clz_if.clz_ready  = ready_r;
    assign clz_if.clz_result = {26'd0, result_r};

endmodule

// File: tb/tb_antares_clz_unit.sv
// Directed testbench for antares_clz_unit with a latency-countdown reference model.
module tb_antares_clz_unit;

    logic clk;
    logic rst;
    antares_clz_unit_if bus();

    antares_clz_unit dut (
        .clk    (clk),
        .rst    (rst),
        .clz_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles of busy left (1 = ready cycle).
    int          m_left  = 0;
    bit          m_valid = 1'b0;
    int          m_pend_cnt = 0;
    logic [31:0] m_pend_norm = 32'h0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_norm = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_count(input logic [31:0] v, input logic op);
        logic [31:0] x;
        int n;
        x = op ? ~v : v;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_norm(input logic [31:0] v, input int cnt);
`ifdef ANTARES_CLZ_NORMALIZE_EN
        if (cnt >= 32) return 32'h0;
        return v << cnt;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] sel_norm(input logic [31:0] with_feature);
`ifdef ANTARES_CLZ_NORMALIZE_EN
        return with_feature;
`else
        return 32'h0;
`endif
    endfunction

    // Model: advance on every rising edge from the sampled inputs.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_left  = 0;
            m_res   = 32'h0;
            m_norm  = 32'h0;
            m_valid = 1'b1;
        end else if (m_left == 0) begin
            if (bus.clz_start && !bus.clz_abort) begin
                m_pend_cnt  = ref_count(bus.clz_operand, bus.clz_op);
                m_pend_norm = ref_norm(bus.clz_operand, m_pend_cnt);
                m_left      = (m_pend_cnt == 32) ? 1 : 6;
            end
        end else if (bus.clz_abort) begin
            m_left = 0;
        end else begin
            m_left = m_left - 1;
        end
        if (m_left == 1) begin
            m_res  = m_pend_cnt;
            m_norm = m_pend_norm;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check32("busy",       {31'd0, bus.clz_busy},  {31'd0, (m_left != 0)});
            check32("ready",      {31'd0, bus.clz_ready}, {31'd0, (m_left == 1)});
            check32("result",     bus.clz_result,     m_res);
            check32("normalized", bus.clz_normalized, m_norm);
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Issue one operation and check ready latency and final values.
    task automatic run_op(input string name, input logic [31:0] opnd, input logic op,
                          input int exp_lat, input logic [31:0] exp_res, input logic [31:0] exp_norm_feat);
        int lat;
        lat = 0;
        bus.clz_operand = opnd;
        bus.clz_op      = op;
        bus.clz_start   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.clz_ready) begin
                lat = i;
                break;
            end
        end
        check32({name, " latency"}, lat, exp_lat);
        check32({name, " result"}, bus.clz_result, exp_res);
        check32({name, " normalized"}, bus.clz_normalized, sel_norm(exp_norm_feat));
        cyc();
        cyc();
    endtask

    initial begin
        int seen_ready;
        rst = 1'b0;
        bus.clz_operand = 32'h0;
        bus.clz_op      = 1'b0;
        bus.clz_start   = 1'b0;
        bus.clz_abort   = 1'b0;
        cyc();
        cyc();
        check32("reset busy",   {31'd0, bus.clz_busy},  32'h0);
        check32("reset ready",  {31'd0, bus.clz_ready}, 32'h0);
        check32("reset result", bus.clz_result,         32'h0);
        check32("reset norm",   bus.clz_normalized,     32'h0);
        rst = 1'b1;
        cyc();

        // Pin the reference model itself with hand-computed counts.
        check32("model clz 00010000", ref_count(32'h0001_0000, 1'b0), 32'd15);
        check32("model clo FFF12345", ref_count(32'hFFF1_2345, 1'b1), 32'd12);
        check32("model clz 0",        ref_count(32'h0000_0000, 1'b0), 32'd32);

        run_op("clz 00010000", 32'h0001_0000, 1'b0, 6, 32'd15, 32'h8000_0000);
        run_op("clo FFF12345", 32'hFFF1_2345, 1'b1, 6, 32'd12, 32'h1234_5000);
        run_op("clz 0",        32'h0000_0000, 1'b0, 1, 32'd32, 32'h0);
        run_op("clo FFFFFFFF", 32'hFFFF_FFFF, 1'b1, 1, 32'd32, 32'h0);
        run_op("clz 80000000", 32'h8000_0000, 1'b0, 6, 32'd0,  32'h8000_0000);
        run_op("clz 00000001", 32'h0000_0001, 1'b0, 6, 32'd31, 32'h8000_0000);
        run_op("clo 7FFFFFFF", 32'h7FFF_FFFF, 1'b1, 6, 32'd0,  32'h7FFF_FFFF);

        // Start while busy is ignored.
        bus.clz_operand = 32'h0000_FFFF;
        bus.clz_op      = 1'b0;
        bus.clz_start   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        cyc();
        cyc();
        bus.clz_operand = 32'h0000_0001;
        bus.clz_start   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check32("ignored start result", bus.clz_result, 32'd16);
        check32("ignored start norm",   bus.clz_normalized, sel_norm(32'hFFFF_0000));

        // Abort in cycle 3: no ready, result holds.
        seen_ready = 0;
        bus.clz_operand = 32'h0000_0001;
        bus.clz_start   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        cyc();
        cyc();
        bus.clz_abort   = 1'b1;
        cyc();
        bus.clz_abort   = 1'b0;
        @(negedge clk);
        check32("abort busy cycle 4", {31'd0, bus.clz_busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.clz_ready) seen_ready++;
        end
        check32("abort ready pulses", seen_ready, 32'd0);
        check32("abort result hold",  bus.clz_result, 32'd16);
        cyc();

        // Start together with abort in IDLE does nothing.
        bus.clz_operand = 32'h0000_0001;
        bus.clz_start   = 1'b1;
        bus.clz_abort   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        bus.clz_abort   = 1'b0;
        @(negedge clk);
        check32("idle abort busy", {31'd0, bus.clz_busy}, 32'h0);
        for (int i = 0; i < 7; i++) cyc();
        check32("idle abort result", bus.clz_result, 32'd16);

        // Reset in cycle 4 of an operation.
        bus.clz_operand = 32'h0001_0000;
        bus.clz_start   = 1'b1;
        cyc();
        bus.clz_start   = 1'b0;
        cyc();
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check32("mid reset busy c4", {31'd0, bus.clz_busy}, 32'h1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check32("mid reset busy",   {31'd0, bus.clz_busy},  32'h0);
        check32("mid reset ready",  {31'd0, bus.clz_ready}, 32'h0);
        check32("mid reset result", bus.clz_result,         32'h0);
        cyc();
        run_op("after reset", 32'h0000_0F00, 1'b0, 6, 32'd20, 32'hF000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
